// File: rtl/ex_stage.sv
// MIPS32 execute stage: single-cycle logic/shift ALU plus a multi-cycle
// radix-2 restoring divider that writes HI/LO and stalls the front of the pipe.
module ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [REG_AW-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              annul_i,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              stallreq_o
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_W - 1);

  localparam logic [7:0] OpAnd  = 8'b0010_0100;
  localparam logic [7:0] OpOr   = 8'b0010_0101;
  localparam logic [7:0] OpXor  = 8'b0010_0110;
  localparam logic [7:0] OpNor  = 8'b0010_0111;
  localparam logic [7:0] OpSll  = 8'b0111_1100;
  localparam logic [7:0] OpSrl  = 8'b0000_0010;
  localparam logic [7:0] OpSra  = 8'b0000_0011;
  localparam logic [7:0] OpDiv  = 8'b0001_1010;
  localparam logic [7:0] OpDivu = 8'b0001_1011;

  localparam logic [2:0] SelLogic = 3'b001;
  localparam logic [2:0] SelShift = 3'b010;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;   // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              quo_neg_q, quo_neg_d;
  logic              rem_neg_q, rem_neg_d;

  logic              div_op;
  logic              div_signed;
  logic [CntW-1:0]   shamt;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;
  logic              stall;
  logic              done_pulse;
  logic [DATA_W-1:0] hi_res;
  logic [DATA_W-1:0] lo_res;

  assign div_op     = (aluop_i == OpDiv) || (aluop_i == OpDivu);
  assign div_signed = (aluop_i == OpDiv);
  assign shamt      = reg1_i[CntW-1:0];

  always_comb begin
    alu_res = '0;
    case (alusel_i)
      SelLogic: begin
        case (aluop_i)
          OpAnd:   alu_res = reg1_i & reg2_i;
          OpOr:    alu_res = reg1_i | reg2_i;
          OpXor:   alu_res = reg1_i ^ reg2_i;
          OpNor:   alu_res = ~(reg1_i | reg2_i);
          default: alu_res = '0;
        endcase
      end
      SelShift: begin
        case (aluop_i)
          OpSll:   alu_res = reg2_i << shamt;
          OpSrl:   alu_res = reg2_i >> shamt;
          OpSra:   alu_res = $signed(reg2_i) >>> shamt;
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  assign abs1 = (div_signed && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
  assign abs2 = (div_signed && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

  // Trial subtract is one bit wider so the borrow lands in the MSB.
  assign shifted = {rem_q, dvd_q[DATA_W-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d    = state_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    stall      = 1'b0;
    done_pulse = 1'b0;
    hi_res     = '0;
    lo_res     = '0;

    if (annul_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (div_op) begin
            stall = 1'b1;
            if (reg2_i == '0) begin
              // Divide by zero: fixed result, no sign fix-up.
              dvd_d     = '1;
              rem_d     = reg1_i;
              quo_neg_d = 1'b0;
              rem_neg_d = 1'b0;
              state_d   = StDone;
            end else begin
              dvd_d     = abs1;
              dsr_d     = abs2;
              rem_d     = '0;
              cnt_d     = '0;
              quo_neg_d = div_signed & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
              rem_neg_d = div_signed & reg1_i[DATA_W-1];
              state_d   = StBusy;
            end
          end
        end
        StBusy: begin
          stall = 1'b1;
          if (!trial[DATA_W]) begin
            rem_d = trial[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b1};
          end else begin
            rem_d = shifted[DATA_W-1:0];
            dvd_d = {dvd_q[DATA_W-2:0], 1'b0};
          end
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
        StDone: begin
          done_pulse = 1'b1;
          hi_res     = rem_neg_q ? -rem_q : rem_q;
          lo_res     = quo_neg_q ? -dvd_q : dvd_q;
          state_d    = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    whilo_o    = 1'b0;
    hi_o       = '0;
    lo_o       = '0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o       = wd_i;
      // Divides never write a GPR, including on their completion cycle.
      wreg_o     = wreg_i & ~div_op & (state_q != StDone);
      wdata_o    = alu_res;
      whilo_o    = done_pulse;
      hi_o       = hi_res;
      lo_o       = lo_res;
      stallreq_o = stall;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: random ALU ops and divides against a
// plain-arithmetic reference model, plus directed annul/reset scenarios.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_AND  = 8'b0010_0100;
  localparam logic [7:0] OP_OR   = 8'b0010_0101;
  localparam logic [7:0] OP_XOR  = 8'b0010_0110;
  localparam logic [7:0] OP_NOR  = 8'b0010_0111;
  localparam logic [7:0] OP_SLL  = 8'b0111_1100;
  localparam logic [7:0] OP_SRL  = 8'b0000_0010;
  localparam logic [7:0] OP_SRA  = 8'b0000_0011;
  localparam logic [7:0] OP_DIV  = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU = 8'b0001_1011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg, annul;

  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o, lo_o;
  logic        stallreq_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] op_tab [8] = '{OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA};
  logic [2:0] sel_tab [4] = '{SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH};

  ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop),
    .alusel_i   (alusel),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .wd_i       (wd),
    .wreg_i     (wreg),
    .annul_i    (annul),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
    int amt;
    logic [31:0] ones;
    amt  = int'(a[4:0]);
    ones = 32'hFFFF_FFFF;
    if (sel == SEL_LOGIC) begin
      if (op == OP_AND) return a & b;
      if (op == OP_OR)  return a | b;
      if (op == OP_XOR) return a ^ b;
      if (op == OP_NOR) return ~(a | b);
    end else if (sel == SEL_SHIFT) begin
      if (op == OP_SLL) return b << amt;
      if (op == OP_SRL) return b >> amt;
      if (op == OP_SRA) return (b >> amt) | (b[31] ? ~(ones >> amt) : 32'h0);
    end
    return 32'h0;
  endfunction

  task automatic model_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb;
    if (b == 32'h0) begin
      eh = a;
      el = 32'hFFFF_FFFF;
    end else if (op == OP_DIVU) begin
      el = a / b;
      eh = a % b;
    end else begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      el = 32'(sa / sb);
      eh = 32'(sa % sb);
    end
  endtask

  // Issues one divide at a cycle start and follows it to its completion pulse.
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int lat;
    model_div(op, a, b, eh, el);
    lat    = (b == 32'h0) ? 1 : 33;
    aluop  = op;
    alusel = SEL_ARITH;
    reg1   = a;
    reg2   = b;
    wd     = 5'($urandom);
    wreg   = 1'b1;
    annul  = 1'b0;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      check("div_stall", 64'(stallreq_o), 64'd1);
      check("div_whilo_early", 64'(whilo_o), 64'd0);
      check("div_wreg", 64'(wreg_o), 64'd0);
      next_cycle();
    end
    @(negedge clk);
    check("div_whilo", 64'(whilo_o), 64'd1);
    check("div_hi", 64'(hi_o), 64'(eh));
    check("div_lo", 64'(lo_o), 64'(el));
    check("div_stall_done", 64'(stallreq_o), 64'd0);
    check("div_wreg_done", 64'(wreg_o), 64'd0);
    next_cycle();
  endtask

  task automatic apply_nop();
    aluop  = OP_NOP;
    alusel = SEL_NOP;
    reg1   = $urandom;
    reg2   = $urandom;
    wd     = 5'($urandom);
    wreg   = 1'b0;
    annul  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a, b;

    rst = 1'b0;
    apply_nop();

    // Outputs stay zero under reset whatever is presented.
    for (int i = 0; i < 4; i++) begin
      aluop  = (i % 2 == 0) ? OP_DIV : OP_OR;
      alusel = (i % 2 == 0) ? SEL_ARITH : SEL_LOGIC;
      reg1   = $urandom;
      reg2   = $urandom;
      wd     = 5'($urandom);
      wreg   = 1'b1;
      @(negedge clk);
      check("rst_zero", 64'(|{wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o}), 64'd0);
      next_cycle();
    end
    rst = 1'b1;

    // Directed OR
    aluop = OP_OR; alusel = SEL_LOGIC; reg1 = 32'h0000_1100; reg2 = 32'h0000_0101;
    wd = 5'd5; wreg = 1'b1; annul = 1'b0;
    @(negedge clk);
    check("or_wdata", 64'(wdata_o), 64'h0000_1101);
    check("or_wd", 64'(wd_o), 64'd5);
    check("or_wreg", 64'(wreg_o), 64'd1);
    check("or_stall", 64'(stallreq_o), 64'd0);
    next_cycle();

    // Directed SRA sign fill and SLL by zero
    aluop = OP_SRA; alusel = SEL_SHIFT; reg1 = 32'd4; reg2 = 32'h8000_0000;
    @(negedge clk);
    check("sra_wdata", 64'(wdata_o), 64'hF800_0000);
    next_cycle();
    aluop = OP_SLL; reg1 = 32'hFFFF_FFE0; reg2 = 32'h1234_5678;
    @(negedge clk);
    check("sll0_wdata", 64'(wdata_o), 64'h1234_5678);
    next_cycle();

    // Random logic/shift/nop traffic
    for (int i = 0; i < 200; i++) begin
      op  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : op_tab[$urandom_range(0, 7)];
      if (op == OP_DIV || op == OP_DIVU) op = OP_NOP;
      sel = ($urandom_range(0, 4) == 0) ? 3'($urandom) : sel_tab[$urandom_range(1, 2)];
      a   = $urandom;
      if ($urandom_range(0, 5) == 0) a[4:0] = 5'd0;
      b   = $urandom;
      aluop = op; alusel = sel; reg1 = a; reg2 = b;
      wd = 5'($urandom); wreg = 1'($urandom); annul = 1'($urandom);
      @(negedge clk);
      check("alu_wdata", 64'(wdata_o), 64'(model_alu(op, sel, a, b)));
      check("alu_wd", 64'(wd_o), 64'(wd));
      check("alu_wreg", 64'(wreg_o), 64'(wreg));
      check("alu_stall", 64'(stallreq_o), 64'd0);
      check("alu_hilo", {31'h0, whilo_o, 32'h0} | 64'({hi_o, lo_o}), 64'd0);
      next_cycle();
    end

    // Directed divides
    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    do_div(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
    do_div(OP_DIVU, 32'd5, 32'd0);
    do_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Back-to-back: second divide accepted in the IDLE cycle after DONE
    do_div(OP_DIVU, 32'd1000, 32'd7);
    do_div(OP_DIV, 32'd77, 32'hFFFF_FFF6);

    // Random divides
    for (int i = 0; i < 24; i++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1, 2:    b = $urandom;
        default: begin
          b = 32'($urandom_range(1, 1000));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
      endcase
      do_div(op, a, b);
      if ($urandom_range(0, 1) == 1) begin
        apply_nop();
        @(negedge clk);
        check("gap_whilo", 64'(whilo_o), 64'd0);
        next_cycle();
      end
    end

    // Annul in cycle 10 of a DIV
    aluop = OP_DIV; alusel = SEL_ARITH; reg1 = 32'd100; reg2 = 32'd7; wreg = 1'b1; annul = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("annul_pre_stall", 64'(stallreq_o), 64'd1);
      next_cycle();
    end
    annul = 1'b1;
    @(negedge clk);
    check("annul_stall", 64'(stallreq_o), 64'd0);
    check("annul_whilo", 64'(whilo_o), 64'd0);
    next_cycle();
    do_div(OP_DIVU, 32'd9, 32'd3);

    // A divide presented with annul is never started
    aluop = OP_DIVU; alusel = SEL_ARITH; reg1 = 32'd50; reg2 = 32'd5; annul = 1'b1;
    @(negedge clk);
    check("annul_start_stall", 64'(stallreq_o), 64'd0);
    next_cycle();
    apply_nop();
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      check("annul_idle", 64'({whilo_o, stallreq_o}), 64'd0);
      next_cycle();
    end

    // Reset in cycle 15 of a DIV
    aluop = OP_DIV; alusel = SEL_ARITH; reg1 = 32'h1234_5678; reg2 = 32'd3; wreg = 1'b1;
    for (int k = 0; k < 15; k++) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_zero", 64'(|{wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o}), 64'd0);
    next_cycle();
    rst = 1'b1;
    apply_nop();
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      check("postrst_idle", 64'({whilo_o, stallreq_o}), 64'd0);
      next_cycle();
    end
    do_div(OP_DIV, 32'hFFFF_FF00, 32'd16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
